pulp_clock_gate_auto: RTL

- Multi-channel automatic clock gater.
- Each channel derives a glitch-free gated copy of clk_i.
- A channel's clock is switched off once that channel reports no activity for IDLE_CYCLES consecutive cycles. It is switched back on at the next activity or force request.
- Placed at subsystem level, in front of peripheral or accelerator clusters. Extends the plain clock AND to N channels with latch-based glitch-free gating, per-channel idle counting, and a test bypass.

---
 rtl/pulp_clock_gate_auto.sv | 97 +++++++++
 1 files changed

// File: rtl/pulp_clock_gate_auto.sv
// Multi-channel automatic clock gater: each channel gates its copy of clk_i after
// IDLE_CYCLES consecutive idle edges and reopens on the next busy or force request.
module pulp_clock_gate_auto #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned IDLE_CYCLES = 16,
    localparam int unsigned CNT_W      = (IDLE_CYCLES == 0) ? 1 : $clog2(IDLE_CYCLES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              test_en_i,
    input  logic [NUM_CH-1:0] busy_i,
    input  logic [NUM_CH-1:0] force_on_i,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] gated_o
);

    typedef enum logic [1:0] {
        StActive,
        StIdleCnt,
        StGated
    } state_e;

    localparam int unsigned IdleLast = (IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(IdleLast);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             en_q;
        logic             en_lat;
        logic             wake;

        assign wake = busy_i[c] | force_on_i[c];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                StActive: begin
                    if (wake) begin
                        cnt_d = '0;
                    end else if (IDLE_CYCLES == 0) begin
                        state_d = StActive;
                    end else if (IDLE_CYCLES == 1) begin
                        state_d = StGated;
                    end else begin
                        state_d = StIdleCnt;
                        cnt_d   = CNT_W'(1);
                    end
                end
                StIdleCnt: begin
                    if (wake) begin
                        state_d = StActive;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StGated;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StGated: begin
                    if (wake) begin
                        state_d = StActive;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StActive;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= StActive;
                cnt_q   <= '0;
                en_q    <= 1'b1;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                en_q    <= (state_d != StGated);
            end
        end

        // Latch only follows the enable while clk_i is low, so the high phase is never cut.
        always_latch begin
            if (!clk_i) begin
                en_lat = en_q | test_en_i;
            end
        end

        assign clk_o[c]   = clk_i & en_lat;
        assign gated_o[c] = ~en_q;
    end

endmodule
